// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and OAM DMA state type.
// Echo-RAM source folding lives here so every bus master folds identically.
package gb_mem_pkg;

    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] DMA_IDLE_ADDR = 16'hFFFF;
    localparam int          OAM_LEN       = 160;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_ADDR,
        RD_CAP,
        WR
    } oam_dma_state_t;

    // Pages E0..FF alias the work RAM 0x2000 lower, so FE/FF read from DE/DF.
    function automatic logic [7:0] fold_src_hi(input logic [7:0] src_hi);
        return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
    endfunction

endpackage

// File: rtl/mem_if.sv
// Byte-wide memory port used between CPU, MMU and DMA engines.
// Master drives address/write fields; slave returns read data.
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (output addr_select, output write_value, output write_enable, input read_out);
    modport slave  (input addr_select, input write_value, input write_enable, output read_out);
endinterface

// File: rtl/oam_dma_m.sv
// OAM DMA: a write to FF46 copies OAM_LEN bytes from {src,00} to FE00, 3 cycles/byte
// after SETUP_CYCLES; a new trigger restarts immediately; all bus outputs registered.
module oam_dma_m
    import gb_mem_pkg::*;
#(
    parameter int OAM_LEN      = gb_mem_pkg::OAM_LEN,
    parameter int SETUP_CYCLES = 1
) (
    input  logic  clk,
    input  logic  rst,
    mem_if.slave  mmio_dma_if,
    mem_if.master dma_req,
    output logic  dma_active
);

    oam_dma_state_t state_q;
    logic [7:0]     idx_q;
    logic [7:0]     setup_cnt_q;
    logic [7:0]     src_hi_q;
    logic [7:0]     data_q;
    logic           prev_we_q;
    logic           active_q;
    logic [15:0]    addr_q;
    logic           we_q;

    logic           trig;
    logic [7:0]     eff_hi;
    logic           last_byte;
    logic           setup_done;

    // Rising edge of write_enable only, so a held CPU write fires once.
    assign trig = mmio_dma_if.write_enable && !prev_we_q
                  && (mmio_dma_if.addr_select == DMA_REG_ADDR);
    assign eff_hi     = fold_src_hi(src_hi_q);
    assign last_byte  = (int'(idx_q) + 1) >= OAM_LEN;
    assign setup_done = (int'(setup_cnt_q) + 1) >= SETUP_CYCLES;

    assign mmio_dma_if.read_out = (mmio_dma_if.addr_select == DMA_REG_ADDR) ? src_hi_q : 8'hFF;

    assign dma_req.addr_select  = addr_q;
    assign dma_req.write_enable = we_q;
    assign dma_req.write_value  = data_q;
    assign dma_active           = active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            setup_cnt_q <= 8'd0;
            src_hi_q    <= 8'hFF;
            data_q      <= 8'd0;
            prev_we_q   <= 1'b0;
            active_q    <= 1'b0;
            addr_q      <= DMA_IDLE_ADDR;
            we_q        <= 1'b0;
        end else begin
            prev_we_q <= mmio_dma_if.write_enable;
            if (trig) begin
                src_hi_q    <= mmio_dma_if.write_value;
                state_q     <= SETUP;
                idx_q       <= 8'd0;
                setup_cnt_q <= 8'd0;
                data_q      <= 8'd0;
                active_q    <= 1'b1;
                addr_q      <= DMA_IDLE_ADDR;
                we_q        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    SETUP: begin
                        if (setup_done) begin
                            state_q <= RD_ADDR;
                            addr_q  <= {eff_hi, idx_q};
                        end else begin
                            setup_cnt_q <= setup_cnt_q + 8'd1;
                        end
                    end
                    RD_ADDR: state_q <= RD_CAP;
                    RD_CAP: begin
                        // Memory answers one cycle after the address; data_q doubles as write data.
                        data_q  <= dma_req.read_out;
                        state_q <= WR;
                        addr_q  <= OAM_BASE + {8'h00, idx_q};
                        we_q    <= 1'b1;
                    end
                    WR: begin
                        we_q   <= 1'b0;
                        data_q <= 8'd0;
                        if (last_byte) begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                            addr_q   <= DMA_IDLE_ADDR;
                        end else begin
                            state_q <= RD_ADDR;
                            idx_q   <= idx_q + 8'd1;
                            addr_q  <= {eff_hi, idx_q + 8'd1};
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        addr_q   <= DMA_IDLE_ADDR;
                        we_q     <= 1'b0;
                        data_q   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_m.sv
// Randomised and directed bench for oam_dma_m against a cycle-count transfer model.
module tb_oam_dma_m;

    localparam int S     = 1;
    localparam int L     = 160;
    localparam int TOTAL = S + 3 * L;

    logic clk = 1'b0;
    logic rst;
    logic act;
    always #5 clk = ~clk;

    mem_if mmio ();
    mem_if dma ();

    oam_dma_m #(.OAM_LEN(L), .SETUP_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .mmio_dma_if (mmio),
        .dma_req     (dma),
        .dma_active  (act)
    );

    // Bench-side memory with one-cycle registered read.
    logic [7:0] mem [0:65535];
    logic [7:0] rd_q;
    assign dma.read_out = rd_q;
    always @(posedge clk) begin
        rd_q <= mem[dma.addr_select];
        if (dma.write_enable) mem[dma.addr_select] <= dma.write_value;
    end

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    int n_act = 0;
    int n_hi  = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] s);
        return (s >= 8'hE0) ? s - 8'h20 : s;
    endfunction

    // Model: a transfer is a count of cycles since the trigger edge.
    bit         m_act  = 0;
    int         m_n    = 0;
    logic [7:0] m_src  = 8'hFF;
    bit         m_prev = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_act  = 0;
            m_src  = 8'hFF;
            m_prev = 0;
        end else begin
            if (mmio.write_enable && mmio.addr_select == 16'hFF46 && !m_prev) begin
                m_act = 1;
                m_n   = 1;
                m_src = mmio.write_value;
            end else if (m_act) begin
                m_n++;
                if (m_n > TOTAL) m_act = 0;
            end
            m_prev = mmio.write_enable;
        end
    end

    int          cm, cb, cph;
    logic [15:0] e_addr, s_addr;
    logic        e_we, e_act, chk_wv;
    logic [7:0]  e_wv;
    always @(posedge clk) begin
        #1;
        e_addr = 16'hFFFF; e_we = 0; e_wv = 8'h00; e_act = 0; chk_wv = 1;
        if (m_act && !rst) begin
            e_act = 1;
            if (m_n > S) begin
                cm  = m_n - S - 1;
                cb  = cm / 3;
                cph = cm % 3;
                s_addr = {fold(m_src), cb[7:0]};
                if (cph < 2) begin
                    e_addr = s_addr; chk_wv = 0;
                end else begin
                    e_addr = 16'hFE00 + 16'(cb); e_we = 1; e_wv = mem[s_addr];
                end
            end
        end
        chk("active", 32'(act), 32'(e_act));
        chk("addr", 32'(dma.addr_select), 32'(e_addr));
        chk("we", 32'(dma.write_enable), 32'(e_we));
        if (chk_wv) chk("wdata", 32'(dma.write_value), 32'(e_wv));
        chk("readback", 32'(mmio.read_out),
            32'((mmio.addr_select == 16'hFF46) ? m_src : 8'hFF));
        if (dma.write_enable) n_wr++;
        if (act) n_act++;
        if (!dma.write_enable && dma.addr_select >= 16'hFE00 && dma.addr_select != 16'hFFFF) n_hi++;
    end

    task automatic idle_bus();
        mmio.addr_select  = 16'hFF46;
        mmio.write_value  = 8'h00;
        mmio.write_enable = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] v, input int hold);
        @(negedge clk);
        mmio.addr_select = a; mmio.write_value = v; mmio.write_enable = 1'b1;
        n_wr = 0; n_act = 0; n_hi = 0;
        repeat (hold) @(negedge clk);
        idle_bus();
    endtask

    int x;
    initial begin
        rst = 1'b1;
        idle_bus();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_active", 32'(act), 32'h0);
        chk("rst_addr", 32'(dma.addr_select), 32'hFFFF);
        chk("rst_rb", 32'(mmio.read_out), 32'hFF);
        @(negedge clk) rst = 1'b0;

        // Basic copy from C100.
        for (int i = 0; i < L; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
        cpu_write(16'hFF46, 8'hC1, 1);
        repeat (500) @(posedge clk);
        chk("basic_act", n_act, 481);
        chk("basic_wr", n_wr, 160);
        chk("basic_fe00", 32'(mem[16'hFE00]), 32'h5A);
        chk("basic_fe01", 32'(mem[16'hFE01]), 32'h5B);
        chk("basic_fe9f", 32'(mem[16'hFE9F]), 32'hC5);

        // Echo folding.
        for (int i = 0; i < L; i++) mem[16'hDE00 + i] = ~8'(i);
        cpu_write(16'hFF46, 8'hFE, 1);
        repeat (500) @(posedge clk);
        chk("echo_hi_rd", n_hi, 0);
        chk("echo_wr", n_wr, 160);
        chk("echo_fe10", 32'(mem[16'hFE10]), 32'hEF);

        // Held write.
        cpu_write(16'hFF46, 8'hC0, 5);
        repeat (500) @(posedge clk);
        chk("held_wr", n_wr, 160);
        chk("held_act", n_act, 481);

        // Restart mid-transfer.
        for (int i = 0; i < L; i++) begin
            mem[16'hC000 + i] = 8'(i) ^ 8'h33;
            mem[16'hC200 + i] = 8'(i) ^ 8'hA5;
        end
        cpu_write(16'hFF46, 8'hC0, 1);
        repeat (98) @(posedge clk);
        cpu_write(16'hFF46, 8'hC2, 1);
        repeat (500) @(posedge clk);
        chk("restart_act", n_act, 481);
        chk("restart_wr", n_wr, 160);
        chk("restart_fe00", 32'(mem[16'hFE00]), 32'hA5);
        chk("restart_fe9f", 32'(mem[16'hFE9F]), 32'h3A);

        // Trigger in the final write cycle.
        cpu_write(16'hFF46, 8'hC0, 1);
        repeat (480) @(posedge clk);
        @(negedge clk);
        chk("coinc_wr1", n_wr, 160);
        mmio.addr_select = 16'hFF46; mmio.write_value = 8'hC0; mmio.write_enable = 1'b1;
        @(negedge clk) idle_bus();
        repeat (500) @(posedge clk);
        chk("coinc_wr2", n_wr, 320);
        chk("coinc_act", n_act, 962);

        // Reset mid-transfer.
        cpu_write(16'hFF46, 8'hC1, 1);
        repeat (199) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_addr", 32'(dma.addr_select), 32'hFFFF);
        chk("mrst_act", 32'(act), 32'h0);
        chk("mrst_we", 32'(dma.write_enable), 32'h0);
        chk("mrst_rb", 32'(mmio.read_out), 32'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b0; n_wr = 0; n_act = 0;
        repeat (100) @(posedge clk);
        chk("mrst_nowr", n_wr, 0);
        chk("mrst_noact", n_act, 0);

        // Readback and bus order.
        cpu_write(16'hFF46, 8'h80, 1);
        @(posedge clk); #2;
        chk("rb_rd0", 32'(dma.addr_select), 32'h8000);
        repeat (2) @(posedge clk); #2;
        chk("rb_wr0", 32'(dma.addr_select), 32'hFE00);
        chk("rb_we0", 32'(dma.write_enable), 32'h1);
        @(posedge clk); #2;
        chk("rb_rd1", 32'(dma.addr_select), 32'h8001);
        chk("rb_mid", 32'(mmio.read_out), 32'h80);
        repeat (500) @(posedge clk); #2;
        chk("rb_after", 32'(mmio.read_out), 32'h80);

        // Random CPU traffic including stray and repeated triggers.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            x = int'($urandom_range(0, 199));
            if (x == 0) begin
                mmio.addr_select = 16'hFF46; mmio.write_enable = 1'b1;
                mmio.write_value = 8'($urandom);
            end else if (x < 20) begin
                mmio.addr_select = 16'($urandom); mmio.write_enable = 1'b1;
                mmio.write_value = 8'($urandom);
            end else begin
                mmio.addr_select = (x[0]) ? 16'hFF46 : 16'($urandom);
                mmio.write_enable = 1'b0;
                mmio.write_value = 8'($urandom);
            end
        end
        @(negedge clk) idle_bus();
        repeat (500) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_m.md
OAM_DMA_M -- requirements
Module: oam_dma_m

Interface
REQ-001 SHALL have parameter OAM_LEN, default 160, the number of bytes copied per transfer.
REQ-002 SHALL have parameter SETUP_CYCLES, default 1, the idle cycles between trigger and first source read.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port mmio_dma_if, mem_if.slave, addr_select 16 / write_value 8 / write_enable 1 / read_out 8, for CPU access to register 0xFF46 through the MMU.
REQ-006 SHALL have port dma_req, mem_if.master, same fields, as the bus-master request into the MMU DMA port.
REQ-007 SHALL have port dma_active, output, 1, high while a transfer is in progress.

Function
REQ-008 SHALL detect a trigger when mmio_dma_if.write_enable=1, addr_select=16'hFF46, and write_enable was 0 in the previous cycle; a held write triggers once.
REQ-009 SHALL latch write_value into the 8-bit register src_hi on trigger.
REQ-010 SHALL return src_hi on mmio_dma_if.read_out combinationally when addr_select=16'hFF46, and 8'hFF otherwise.
REQ-011 SHALL implement the states IDLE, SETUP, RD_ADDR, RD_CAP and WR.
REQ-012 SHALL, on trigger, go to SETUP, clear byte index idx to 0, and hold SETUP for SETUP_CYCLES cycles before RD_ADDR.
REQ-013 SHALL, in RD_ADDR, drive dma_req.addr_select={eff_hi, idx} with write_enable=0.
REQ-014 SHALL, in RD_CAP, hold the RD_ADDR address, capture dma_req.read_out into data_q (1-cycle memory read latency), then go to WR.
REQ-015 SHALL, in WR, drive addr_select=16'hFE00+idx, write_value=data_q and write_enable=1 for exactly one cycle.
REQ-016 SHALL, after WR, increment idx and go to RD_ADDR if idx+1<OAM_LEN, otherwise to IDLE.
REQ-017 SHALL compute eff_hi = src_hi-8'h20 for src_hi>=8'hE0 (sources FE/FF fold onto DE/DF), otherwise eff_hi = src_hi.
REQ-018 SHALL keep idx 8 bits wide and never let it wrap past OAM_LEN-1.
REQ-019 SHALL, in IDLE and SETUP, drive dma_req.addr_select=16'hFFFF with write_enable=0 and write_value=0; the MMU treats 16'hFFFF as no transfer.
REQ-020 SHALL drive dma_active=1 in every state except IDLE.
REQ-021 SHALL make a transfer take SETUP_CYCLES+3*OAM_LEN cycles from the trigger edge to return to IDLE (481 at defaults).
REQ-022 SHALL, on a trigger during an active transfer, relatch src_hi, abort the current byte without a write, and restart in SETUP with idx=0.
REQ-023 SHALL, when a trigger coincides with the final WR cycle, complete that write and then restart.
REQ-024 SHALL ignore writes to addresses other than 16'hFF46.

Reset
REQ-025 SHALL, while rst=1 (including mid-transfer), set state=IDLE, idx=0, src_hi=8'hFF, data_q=0, prev write_enable=0, dma_active=0, dma_req.addr_select=16'hFFFF, write_enable=0 and write_value=0.
REQ-026 SHALL make no further write after reset deasserts until a new trigger.

Structure
REQ-027 SHALL place constants OAM_BASE=16'hFE00, DMA_REG_ADDR=16'hFF46, DMA_IDLE_ADDR=16'hFFFF and OAM_LEN in shared package gb_mem_pkg.
REQ-028 SHALL define the state enum as oam_dma_state_t in gb_mem_pkg.
REQ-029 SHALL be a single flat module with no sub-module; edge detection and the FSM are inline.
REQ-030 SHALL register all dma_req outputs from state and idx.

Verification
REQ-031 SHALL cover basic copy: WRAM C100+i = i^8'h5A, write 8'hC1 to FF46 -> OAM FE00+i = i^8'h5A for i=0..159; dma_active high exactly 481 cycles.
REQ-032 SHALL cover echo folding: write 8'hFE -> reads at 16'hDE00..16'hDE9F; no read of FE00 or above.
REQ-033 SHALL cover held write: write_enable held 5 cycles with 8'hC0 -> exactly one transfer, 160 writes.
REQ-034 SHALL cover restart: 8'hC0 then 8'hC2 at cycle 100 -> the final 160 writes carry C2xx data starting at FE00; dma_active ends 481 cycles after the second trigger.
REQ-035 SHALL cover mid-transfer reset: rst at cycle 200 -> same cycle dma_req.addr_select=16'hFFFF, dma_active=0; FF46 reads 8'hFF; no writes until retrigger.
REQ-036 SHALL cover readback: write 8'h80 -> FF46 reads 8'h80 throughout and after the transfer; the bus sequence is 8000 read, FE00 write, 8001 read, ...
